// File: rtl/ap1000_irq_conditioner.sv
// ap1000_irq_conditioner: turns the raw board interrupt lines into clean,
// active-high per-source pending flags and one combined request.
// Each line is synchronised, normalised to active-high, glitch-filtered, and
// then captured as either an edge source or a level source.
// Optional feature macro: AP1000_IRQ_FILTER_EN enables the per-line glitch
// filter. When it is undefined, the filtered level is simply the registered
// normalised sync2 value.

module ap1000_irq_lane #(
   parameter bit ACTIVE_LOW    = 1'b0,
   parameter bit EDGE          = 1'b0
`ifdef AP1000_IRQ_FILTER_EN
   ,parameter int FILTER_CYCLES = 4
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic irq_in,
   input  logic ack,
   output logic level,
   output logic pending
);

   logic sync1, sync2, norm, level_q;

   // Two-flop synchroniser; it resets to the inactive level so that the reset
   // does not produce a false assertion.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= ACTIVE_LOW;
         sync2 <= ACTIVE_LOW;
      end else begin
         sync1 <= irq_in;
         sync2 <= sync1;
      end
   end

   assign norm = sync2 ^ ACTIVE_LOW;

`ifdef AP1000_IRQ_FILTER_EN
   localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);
   logic [7:0] cnt;

   // Glitch filter: the level follows norm only after norm has disagreed
   // with the level for FILTER_CYCLES consecutive samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= 8'd0;
         level <= 1'b0;
      end else if (norm == level) begin
         cnt   <= 8'd0;
      end else if (cnt == CNT_LAST) begin
         level <= ~level;
         cnt   <= 8'd0;
      end else begin
         cnt   <= cnt + 8'd1;
      end
   end
`else
   // Filter removed: the level is the registered normalised sample.
   always_ff @(posedge clk) begin
      if (rst) level <= 1'b0;
      else     level <= norm;
   end
`endif

   // Capture: on an edge source, a rising level sets pending and ack clears
   // it, with set taking priority. On a level source, pending follows the level.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b0;
         pending <= 1'b0;
      end else begin
         level_q <= level;
         if (EDGE) pending <= (level & ~level_q) | (pending & ~ack);
         else      pending <= level;
      end
   end

endmodule

module ap1000_irq_conditioner #(
   parameter int                   C_NUM_IRQ         = 11,
   parameter logic [C_NUM_IRQ-1:0] C_ACTIVE_LOW_MASK = 11'b111_1111_1110,
   parameter logic [C_NUM_IRQ-1:0] C_EDGE_MASK       = 11'b000_0000_0001,
   parameter int                   C_FILTER_CYCLES   = 4
) (
   input  logic                 OPB_Clk,
   input  logic                 OPB_Rst,
   input  logic [C_NUM_IRQ-1:0] Irq_in,
   input  logic [C_NUM_IRQ-1:0] Irq_enable,
   input  logic [C_NUM_IRQ-1:0] Irq_ack,
   output logic [C_NUM_IRQ-1:0] Irq_level,
   output logic [C_NUM_IRQ-1:0] Irq_pending,
   output logic                 Irq_out
);

   if (C_FILTER_CYCLES < 1 || C_FILTER_CYCLES > 255) begin : g_bad_filter
      $error("C_FILTER_CYCLES must be in 1..255");
   end

   for (genvar i = 0; i < C_NUM_IRQ; i++) begin : g_lane
      ap1000_irq_lane #(
         .ACTIVE_LOW    (C_ACTIVE_LOW_MASK[i]),
         .EDGE          (C_EDGE_MASK[i])
`ifdef AP1000_IRQ_FILTER_EN
         ,.FILTER_CYCLES(C_FILTER_CYCLES)
`endif
      ) u_lane (
         .clk     (OPB_Clk),
         .rst     (OPB_Rst),
         .irq_in  (Irq_in[i]),
         .ack     (Irq_ack[i]),
         .level   (Irq_level[i]),
         .pending (Irq_pending[i])
      );
   end

   // Combined request. The enable gates only this output, so a pending flag
   // that was set while disabled raises the request as soon as it is enabled.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) Irq_out <= 1'b0;
      else         Irq_out <= |(Irq_pending & Irq_enable);
   end

endmodule

// File: tb/tb_ap1000_irq_conditioner.sv
// Bench for ap1000_irq_conditioner: directed test-plan scenarios plus
// randomized stimulus, checked against a window-based behavioural model.
module tb_ap1000_irq_conditioner;

   localparam logic [10:0] AL   = 11'b111_1111_1110;
   localparam logic [10:0] EDGE = 11'b000_0000_0001;
`ifdef AP1000_IRQ_FILTER_EN
   localparam int N   = 4;
   localparam int LVL = 2 + N;   // edge at which the level changes
`else
   localparam int LVL = 3;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] in_l, en, ack;
   logic [10:0] level, pend;
   logic        out;

   int n_chk = 0, n_pass = 0;

   // model state
   logic [10:0] m_s1, m_s2, m_lvl, m_lvq, m_pend;
   logic        m_out;
`ifdef AP1000_IRQ_FILTER_EN
   logic [10:0] hist[$];
`endif

   always #5 clk = ~clk;

   ap1000_irq_conditioner dut (
      .OPB_Clk(clk), .OPB_Rst(rst), .Irq_in(in_l), .Irq_enable(en),
      .Irq_ack(ack), .Irq_level(level), .Irq_pending(pend), .Irq_out(out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
   endtask

   // The model computes the state after the upcoming edge from the current inputs.
   // In the filter model, the level toggles when the last N samples all disagree
   // with it.
   task automatic model_step();
      logic [10:0] norm, nl, np;
      logic        no;
      if (rst) begin
         m_s1 = AL; m_s2 = AL; m_lvl = '0; m_lvq = '0; m_pend = '0; m_out = 1'b0;
`ifdef AP1000_IRQ_FILTER_EN
         hist.delete();
`endif
      end else begin
         norm = m_s2 ^ AL;
`ifdef AP1000_IRQ_FILTER_EN
         hist.push_back(norm);
         if (hist.size() > N) void'(hist.pop_front());
         nl = m_lvl;
         if (hist.size() == N)
            for (int i = 0; i < 11; i++) begin
               bit all_diff = 1'b1;
               foreach (hist[k]) if (hist[k][i] == m_lvl[i]) all_diff = 1'b0;
               if (all_diff) nl[i] = ~m_lvl[i];
            end
`else
         nl = norm;
`endif
         np = (EDGE & ((m_lvl & ~m_lvq) | (m_pend & ~ack))) | (~EDGE & m_lvl);
         no = |(m_pend & en);
         m_s2 = m_s1; m_s1 = in_l; m_lvq = m_lvl; m_lvl = nl; m_pend = np; m_out = no;
      end
   endtask

   // One clock: advance the model, cross the edge, and compare the outputs 1 time unit later.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("level", 32'(level), 32'(m_lvl));
      chk("pending", 32'(pend), 32'(m_pend));
      chk("irq_out", 32'(out), 32'(m_out));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int first, cnt_hi;
      int hold[11];
      rst = 1'b1; in_l = AL; en = 11'h7FF; ack = '0;
      ticks(3);
      rst = 1'b0;

      // 1: idle after reset
      ticks(20);
      chk("rst_level", 32'(level), 0);
      chk("rst_pend", 32'(pend), 0);
      chk("rst_out", 32'(out), 0);

      // 2: PMC INTA asserted (active-low), then released
      in_l[1] = 1'b0;
      for (int e = 1; e <= LVL + 3; e++) begin
         tick();
         chk("s2_lvl", 32'(level[1]), 32'(e >= LVL));
         chk("s2_pend", 32'(pend[1]), 32'(e >= LVL + 1));
         chk("s2_out", 32'(out), 32'(e >= LVL + 2));
      end
      in_l[1] = 1'b1;
      for (int e = 1; e <= LVL + 3; e++) begin
         tick();
         chk("s2_rel_out", 32'(out), 32'(e < LVL + 2));
      end

      // 3: short and qualifying pulses on PS/2 INT2
      for (int len = 3; len <= 4; len++) begin
         cnt_hi = 0;
         in_l[7] = 1'b0;
         for (int e = 0; e < 20; e++) begin
            if (e == len) in_l[7] = 1'b1;
            tick();
            if (level[7]) cnt_hi++;
         end
`ifdef AP1000_IRQ_FILTER_EN
         chk("s3_pulse_len", 32'(cnt_hi), (len >= N) ? 32'(len) : 0);
`else
         chk("s3_pulse_len", 32'(cnt_hi), 32'(len));
`endif
      end

      // 4: SystemACE edge capture, set-beats-ack, lone ack
      in_l[0] = 1'b1;
      ticks(LVL + 1);
      chk("s4_pend_set", 32'(pend[0]), 1);
      in_l[0] = 1'b0;
      ticks(12);
      chk("s4_pend_hold", 32'(pend[0]), 1);
      in_l[0] = 1'b1;
      ticks(LVL);
      ack[0] = 1'b1;
      tick();
      ack[0] = 1'b0;
      chk("s4_set_wins", 32'(pend[0]), 1);
      in_l[0] = 1'b0;
      ticks(12);
      ack[0] = 1'b1;
      tick();
      ack[0] = 1'b0;
      chk("s4_ack_clr", 32'(pend[0]), 0);
      chk("s4_out_lag", 32'(out), 1);
      tick();
      chk("s4_out_fall", 32'(out), 0);

      // 5: pending while disabled, request appears on enable
      en = '0;
      in_l[0] = 1'b1;
      ticks(LVL + 3);
      chk("s5_pend", 32'(pend[0]), 1);
      chk("s5_out_off", 32'(out), 0);
      en = 11'h001;
      tick();
      chk("s5_out_on", 32'(out), 1);
      ack[0] = 1'b1; in_l[0] = 1'b0; en = 11'h7FF;
      tick();
      ack[0] = 1'b0;
      ticks(12);

      // 6: reset in the middle of a filter count on PMC INTC
      in_l[3] = 1'b0;
      ticks(4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      first = 0;
      for (int e = 1; e <= LVL + 3; e++) begin
         tick();
         if (level[3] && first == 0) first = e;
      end
      chk("s6_requal", 32'(first), 32'(LVL));
      in_l[3] = 1'b1;
      ticks(12);

      // random phase: lines held for random durations, with random acks, enables and resets
      foreach (hold[i]) hold[i] = 0;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 11; i++) begin
            if (hold[i] == 0) begin
               in_l[i] = 1'($urandom_range(0, 1));
               hold[i] = $urandom_range(1, 9);
            end
            hold[i]--;
         end
         ack = ($urandom_range(0, 5) == 0) ? 11'($urandom) : '0;
         if ($urandom_range(0, 29) == 0) en = 11'($urandom);
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ap1000_irq_conditioner.md
# ap1000_irq_conditioner

Conditions the raw board interrupt lines (SystemACE, PMC INTA–INTD, PS/2 INT0–INT5) after the board interrupt interface brings them on-chip. It consumes the `*_internal` lines and produces clean, active-high, per-source pending flags and one combined request for the processor interrupt controller. Per line it provides:
- two-flop synchronisation;
- polarity normalisation;
- a glitch filter;
- edge or level capture, with per-source enable and acknowledge.

## Interface
Parameters:
- `C_NUM_IRQ`, 11: number of lines. Bit 0 = SystemACE, bits 1–4 = PMC INTA–INTD, bits 5–10 = PS/2 INT0–INT5.
- `C_ACTIVE_LOW_MASK`, 11'b111_1111_1110: bit set means the line is active-low and is inverted before the filter.
- `C_EDGE_MASK`, 11'b000_0000_0001: bit set means edge-captured; bit clear means level.
- `C_FILTER_CYCLES`, 4: required stable cycles, legal range 1..255. Counter width is 8 bits.

Ports:
- `OPB_Clk`  in  1: single clock. All logic is on its rising edge.
- `OPB_Rst`  in  1: synchronous, active-high reset.
- `Irq_in`  in  C_NUM_IRQ: raw lines, asynchronous to `OPB_Clk`.
- `Irq_enable`  in  C_NUM_IRQ: per-source mask for `Irq_out`.
- `Irq_ack`  in  C_NUM_IRQ: single-cycle clear strobe. Affects edge-mode sources only.
- `Irq_level`  out  C_NUM_IRQ: filtered, normalised (active-high) level.
- `Irq_pending`  out  C_NUM_IRQ: per-source pending flag.
- `Irq_out`  out  1: registered OR of `Irq_pending & Irq_enable`.

## Operation
- Sync: two flops per line (`sync1`, then `sync2`). The normalised value is `sync2 ^ C_ACTIVE_LOW_MASK[i]`.
- Filter, per line, with an 8-bit counter `cnt`:
  - If the normalised value equals `Irq_level[i]`: `cnt` ← 0.
  - Else if `cnt == C_FILTER_CYCLES-1`: `Irq_level[i]` toggles and `cnt` ← 0.
  - Else: `cnt` increments.
  - Consequently, any disagreement shorter than `C_FILTER_CYCLES` cycles is discarded.
- Edge source (`C_EDGE_MASK[i]` = 1):
  - A 0→1 transition of `Irq_level[i]` sets `Irq_pending[i]`.
  - `Irq_ack[i]` clears it.
  - If set and ack occur in the same cycle, set wins and pending stays 1.
  - 1→0 transitions are ignored.
- Level source: `Irq_pending[i]` ← `Irq_level[i]` every cycle. `Irq_ack[i]` is ignored.
- `Irq_enable` gates only `Irq_out`. Pending flags still set while a source is disabled, so enabling it later raises `Irq_out`.
- Reset values, with `OPB_Rst` high at a rising edge:
  - `sync1`/`sync2` load the inactive level for each line (1 if active-low, 0 otherwise).
  - `cnt` = 0, `Irq_level` = 0, `Irq_pending` = 0, `Irq_out` = 0.
- Reset mid-filter discards any partial count. A line still asserted after reset re-qualifies from scratch and, if edge-mode, produces a fresh pending.

## Timing
Edge numbering: the new value on `Irq_in` is set up before edge 1, and N = `C_FILTER_CYCLES`.
- `sync2` updates at edge 2.
- `Irq_level` changes at edge 2+N.
- `Irq_pending` changes at edge 3+N.
- `Irq_out` changes at edge 4+N.
- `Irq_ack` asserted before edge k clears pending at edge k. `Irq_out` falls at edge k+1.
- An `Irq_enable` change before edge k is reflected on `Irq_out` at edge k.
- Every output is a flop. There are no combinational paths from input to output.

## Configuration
- `AP1000_IRQ_FILTER_EN` defined:
  - The filter operates as described above.
  - Latencies include N.
- `AP1000_IRQ_FILTER_EN` undefined:
  - Filter counters are not instantiated and `C_FILTER_CYCLES` is ignored.
  - `Irq_level` is registered from the normalised `sync2`, giving level at edge 3, pending at edge 4 and `Irq_out` at edge 5.
  - Glitches of one cycle or longer that reach `sync2` propagate.

## Test plan
All scenarios use the default parameters with `AP1000_IRQ_FILTER_EN` defined, unless stated.
1. Reset release with all lines inactive (`Irq_in` = 11'b111_1111_1110): after 20 cycles, `Irq_level`, `Irq_pending` and `Irq_out` are all 0.
2. Drive PMC INTA (bit 1) low and hold, with `Irq_enable` = 11'h7FF:
   - `Irq_level[1]` = 1 at edge 6.
   - `Irq_pending[1]` = 1 at edge 7.
   - `Irq_out` = 1 at edge 8.
   - Release the line: `Irq_out` = 0 at edge 8 after release.
3. Pulse PS/2 INT2 (bit 7) low for 3 cycles: `Irq_level[7]`, `Irq_pending[7]` and `Irq_out` stay 0. Repeat with a 4-cycle pulse: `Irq_level[7]` goes high for exactly 4 cycles.
4. SystemACE (bit 0) rises:
   - `Irq_pending[0]` = 1 and stays 1 after the line falls.
   - Ack in the same cycle as a second qualified rising edge leaves pending at 1.
   - A lone ack clears pending, and `Irq_out` falls one edge later.
5. With `Irq_enable` = 0, qualify the SystemACE (bit 0) edge: pending = 1 and `Irq_out` = 0. Set `Irq_enable[0]` = 1: `Irq_out` = 1 at the next edge.
6. Assert `OPB_Rst` for 1 cycle while bit 3 has `cnt` = 2, then keep bit 3 asserted: `Irq_level[3]` rises 2+N edges after reset release. Rebuild without the macro and repeat scenario 2: level at edge 3, `Irq_out` at edge 5.
